// File: rtl/fd_skid_buffer.sv
// Fetch-to-decode pipeline register as a 2-entry skid buffer with valid/ready handshake,
// branch flush and a saturating stall counter.
module fd_skid_buffer #(
  parameter int unsigned      DBITS     = 32,
  parameter logic [DBITS-1:0] NOOP_WORD = DBITS'(32'h0000_0000),
  parameter int unsigned      CWIDTH    = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DBITS-1:0]  incPC_F,
  input  logic [DBITS-1:0]  instWord_F,
  input  logic              noop_F,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DBITS-1:0]  incPC_D,
  output logic [DBITS-1:0]  instWord_D,
  output logic              noop_D,
  output logic [CWIDTH-1:0] stall_cnt
);

  // State encoding mirrors {skid_valid, main_valid}
  localparam logic [1:0] ST_EMPTY = 2'b00;
  localparam logic [1:0] ST_ONE   = 2'b01;
  localparam logic [1:0] ST_FULL  = 2'b11;

  logic [1:0]       state, state_n;
  logic [DBITS-1:0] main_pc_n, main_inst_n;
  logic             main_noop_n;
  logic [DBITS-1:0] skid_pc, skid_inst, skid_pc_n, skid_inst_n;
  logic             skid_noop, skid_noop_n;
  logic             in_ready_n, out_valid_n;
  logic             in_fire, out_fire;

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  // Next-state and next-contents; main data is forced to bubble values whenever main empties
  always_comb begin
    state_n     = state;
    main_pc_n   = incPC_D;
    main_inst_n = instWord_D;
    main_noop_n = noop_D;
    skid_pc_n   = skid_pc;
    skid_inst_n = skid_inst;
    skid_noop_n = skid_noop;

    if (flush) begin
      state_n     = ST_EMPTY;
      main_pc_n   = '0;
      main_inst_n = NOOP_WORD;
      main_noop_n = 1'b1;
      skid_pc_n   = '0;
      skid_inst_n = NOOP_WORD;
      skid_noop_n = 1'b1;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (in_fire) begin
            state_n     = ST_ONE;
            main_pc_n   = incPC_F;
            main_inst_n = instWord_F;
            main_noop_n = noop_F;
          end
        end
        ST_ONE: begin
          if (in_fire && out_fire) begin
            main_pc_n   = incPC_F;
            main_inst_n = instWord_F;
            main_noop_n = noop_F;
          end else if (in_fire) begin
            state_n     = ST_FULL;
            skid_pc_n   = incPC_F;
            skid_inst_n = instWord_F;
            skid_noop_n = noop_F;
          end else if (out_fire) begin
            // incPC_D keeps the consumed entry's PC
            state_n     = ST_EMPTY;
            main_inst_n = NOOP_WORD;
            main_noop_n = 1'b1;
          end
        end
        ST_FULL: begin
          if (out_fire) begin
            state_n     = ST_ONE;
            main_pc_n   = skid_pc;
            main_inst_n = skid_inst;
            main_noop_n = skid_noop;
          end
        end
        default: begin
          state_n     = ST_EMPTY;
          main_pc_n   = '0;
          main_inst_n = NOOP_WORD;
          main_noop_n = 1'b1;
        end
      endcase
    end

    out_valid_n = (state_n != ST_EMPTY);
    in_ready_n  = (state_n != ST_FULL);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_EMPTY;
      out_valid  <= 1'b0;
      in_ready   <= 1'b1;
      incPC_D    <= '0;
      instWord_D <= NOOP_WORD;
      noop_D     <= 1'b1;
      skid_pc    <= '0;
      skid_inst  <= NOOP_WORD;
      skid_noop  <= 1'b1;
    end else begin
      state      <= state_n;
      out_valid  <= out_valid_n;
      in_ready   <= in_ready_n;
      incPC_D    <= main_pc_n;
      instWord_D <= main_inst_n;
      noop_D     <= main_noop_n;
      skid_pc    <= skid_pc_n;
      skid_inst  <= skid_inst_n;
      skid_noop  <= skid_noop_n;
    end
  end

  // Stall counter survives flush; only reset clears it
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt <= '0;
    end else if (out_valid && !out_ready && (stall_cnt != {CWIDTH{1'b1}})) begin
      stall_cnt <= stall_cnt + CWIDTH'(1);
    end
  end

endmodule

// File: doc/fd_skid_buffer.md
Name: fd_skid_buffer

Overview:
- Parametrised successor to the fetch/decode pipeline register.
- Carries incPC, instWord and a noop flag from fetch to decode through a 2-entry skid buffer with a valid/ready handshake.
- Supports a flush (branch squash), which replaces the plain write enable.
- Adds a saturating stall counter for performance monitoring.
- Full throughput: one transfer per cycle when downstream is ready.

Parameters:
- DBITS, 32, width of incPC and instWord fields.
- NOOP_WORD, 32'h0000_0000, instWord value driven whenever no valid entry is presented (DBITS wide).
- CWIDTH, 16, width of the stall counter.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- flush  input  1  synchronous squash of all held entries.
- in_valid  input  1  fetch presents an entry.
- in_ready  output  1  buffer can accept; registered, equals NOT skid_valid.
- incPC_F  input  DBITS  incremented PC from fetch.
- instWord_F  input  DBITS  instruction word from fetch.
- noop_F  input  1  entry is a bubble.
- out_valid  output  1  main entry valid.
- out_ready  input  1  decode can consume.
- incPC_D  output  DBITS  main entry PC.
- instWord_D  output  DBITS  main entry instruction.
- noop_D  output  1  main entry bubble flag.
- stall_cnt  output  CWIDTH  cycles with out_valid=1 and out_ready=0; saturating.

Behaviour:
- Storage and fire conditions:
  - Two entries: main (drives outputs) and skid. Each entry holds {incPC, instWord, noop, valid}.
  - in_fire = in_valid & in_ready.
  - out_fire = out_valid & out_ready.
- Reset (reset=0, asynchronous):
  - Both valids 0, so out_valid=0 and in_ready=1.
  - incPC_D=0, instWord_D=NOOP_WORD, noop_D=1, stall_cnt=0.
  - The reset state holds until the first clk edge after reset returns to 1.
- States are derived from the valids:
  - EMPTY: main=0, skid=0.
  - ONE: main=1, skid=0.
  - FULL: main=1, skid=1.
  - Skid valid with main invalid is illegal and never reached.
- Transitions (no flush):
  - EMPTY: in_fire loads main, next state ONE. Latency from accept to out_valid is 1 cycle.
  - ONE, in_fire & out_fire: main reloaded from input, stays ONE.
  - ONE, in_fire only: skid loaded, next state FULL, in_ready=0 next cycle.
  - ONE, out_fire only: next state EMPTY.
  - FULL: in_fire cannot occur. out_fire moves skid to main, next state ONE, in_ready=1 next cycle.
  - Any state with no fire: contents held unchanged.
- Flush:
  - Highest priority. The next state is EMPTY regardless of handshakes.
  - An in_fire in the flush cycle is discarded.
  - An out_fire in the flush cycle still counts as consumed by decode.
  - After a flush, output data takes the reset values: incPC_D=0, instWord_D=NOOP_WORD, noop_D=1.
- Invalid-main outputs:
  - Whenever main is invalid, instWord_D=NOOP_WORD and noop_D=1. incPC_D holds its last value, or 0 after reset or flush.
- Noop entries:
  - Handshake like normal entries. The buffer never drops them.
- Stall counter:
  - Increments on each clk edge where out_valid=1 and out_ready=0; saturates at all-ones.
  - Not cleared by flush. Cleared only by reset.
- Reset asserted mid-operation:
  - All state clears immediately, including a FULL buffer and stall_cnt.

Test Plan:
1. Reset then single pass:
   - Release reset, apply in_valid=1, incPC_F=44, instWord_F=1101029, noop_F=1, out_ready=1 for 1 cycle.
   - Next cycle: out_valid=1, incPC_D=44, instWord_D=1101029, noop_D=1. Following cycle: out_valid=0, instWord_D=NOOP_WORD.
2. Backpressure fill:
   - out_ready=0; send A(PC=44), then B(PC=19).
   - in_ready drops after B. stall_cnt counts each held cycle. C is held at the input, not accepted.
   - Raise out_ready: order A, B, C with no loss or duplication.
   - in_ready returns to 1 one cycle after A is consumed.
3. Streaming:
   - out_ready=1, in_valid=1 for 8 cycles with PC=0..7.
   - out_valid is continuous for 8 cycles, PCs in order, in_ready never 0.
4. Flush in FULL:
   - Buffer holds A, B; assert flush with in_valid=1 (PC=99).
   - Next cycle: out_valid=0, noop_D=1, in_ready=1. PC=99 is never output. stall_cnt retained.
5. Async reset mid-stream:
   - Drive reset=0 between clock edges while FULL.
   - out_valid=0, stall_cnt=0, in_ready=1 immediately, without waiting for a clk edge.
6. Stall saturation:
   - CWIDTH=4, hold out_valid=1 with out_ready=0 for 20 cycles.
   - stall_cnt=15 and stays at 15.
